// File: rtl/crossing_pkg.sv
// crossing_pkg: shared types and limits for the toggle-handshake word crossing.
package crossing_pkg;
    typedef enum logic {EMPTY, FULL} rx_state_e;
    localparam int CROSSING_MIN_STAGES = 2;
endpackage

// File: rtl/crossing_word_rx_if.sv
// crossing_word_rx_if: source-toggle and local valid/ready signals of the crossing receiver.
interface crossing_word_rx_if #(parameter int width = 1);
    logic [width-1:0] SRC_DATA;
    logic             SRC_TOG;
    logic             ACK_TOG;
    logic [width-1:0] OUT_DATA;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic             OVERRUN;
    logic             OVERRUN_CLR;
    modport master (output SRC_DATA, SRC_TOG, OUT_READY, OVERRUN_CLR,
                    input  ACK_TOG, OUT_DATA, OUT_VALID, OVERRUN);
    modport slave  (input  SRC_DATA, SRC_TOG, OUT_READY, OVERRUN_CLR,
                    output ACK_TOG, OUT_DATA, OUT_VALID, OVERRUN);
endinterface

// File: rtl/sync_bit_n.sv
// sync_bit_n: stages-deep single-bit synchronizer, async active-low reset to 0.
module sync_bit_n #(
    parameter int stages = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [stages-1:0] sync_q;
    logic [stages-1:0] sync_d;
    always_comb sync_d = {sync_q[stages-2:0], d};
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    assign q = sync_q[stages-1];
endmodule

// File: rtl/crossing_word_rx.sv
// crossing_word_rx: destination side of a toggle-handshake word crossing.
// Optional sticky overrun flag enabled by CROSSING_RX_OVERRUN_EN.
module crossing_word_rx
    import crossing_pkg::*;
#(
    parameter int               width  = 1,
    parameter logic [width-1:0] init   = '0,
    parameter int               stages = 2
) (
    input logic               CLK,
    input logic               RST_N,
    crossing_word_rx_if.slave bus
);
    if (stages < CROSSING_MIN_STAGES) begin : g_bad_stages
        $error("crossing_word_rx: stages must be at least %0d", CROSSING_MIN_STAGES);
    end

    rx_state_e        state_q, state_d;
    logic             tog_seen_q, tog_seen_d;
    logic             ack_q, ack_d;
    logic [width-1:0] data_q, data_d;
    logic             ovr_q, ovr_d;
    logic             ovr_set;
    logic             tog_sync;
    logic             tog_edge;

    sync_bit_n #(.stages(stages)) u_sync (
        .clk   (CLK),
        .rst_n (RST_N),
        .d     (bus.SRC_TOG),
        .q     (tog_sync)
    );

    assign tog_edge = tog_sync != tog_seen_q;

    // A consume and a fresh edge in the same cycle hand over directly without an overrun.
    always_comb begin
        state_d    = state_q;
        tog_seen_d = tog_seen_q;
        ack_d      = ack_q;
        data_d     = data_q;
        ovr_set    = 1'b0;
        if (state_q == EMPTY) begin
            if (tog_edge) begin
                data_d     = bus.SRC_DATA;
                tog_seen_d = tog_sync;
                state_d    = FULL;
            end
        end else if (bus.OUT_READY) begin
            ack_d = ~ack_q;
            if (tog_edge) begin
                data_d     = bus.SRC_DATA;
                tog_seen_d = tog_sync;
            end else begin
                state_d = EMPTY;
            end
        end else if (tog_edge) begin
            tog_seen_d = tog_sync;
            ovr_set    = 1'b1;
        end
    end

`ifdef CROSSING_RX_OVERRUN_EN
    always_comb ovr_d = ovr_set | (ovr_q & ~bus.OVERRUN_CLR);
`else
    logic unused_ovr;
    assign unused_ovr = ovr_set ^ bus.OVERRUN_CLR;
    always_comb ovr_d = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) begin
            state_q    <= EMPTY;
            tog_seen_q <= 1'b0;
            ack_q      <= 1'b0;
            data_q     <= init;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tog_seen_q <= tog_seen_d;
            ack_q      <= ack_d;
            data_q     <= data_d;
            ovr_q      <= ovr_d;
        end

    assign bus.ACK_TOG   = ack_q;
    assign bus.OUT_DATA  = data_q;
    assign bus.OUT_VALID = state_q == FULL;
    assign bus.OVERRUN   = ovr_q;
endmodule

// File: tb/tb_crossing_word_rx.sv
// tb_crossing_word_rx: scoreboard bench for crossing_word_rx at depths 2 and 3.
module tb_crossing_word_rx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    localparam logic [7:0] INIT = 8'hC3;
`ifdef CROSSING_RX_OVERRUN_EN
    localparam logic OVR_EN = 1'b1;
`else
    localparam logic OVR_EN = 1'b0;
`endif

    crossing_word_rx_if #(.width(8)) bus_a ();
    crossing_word_rx_if #(.width(8)) bus_b ();

    crossing_word_rx #(.width(8), .init(INIT), .stages(2)) dut_a (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus_a)
    );
    crossing_word_rx #(.width(8), .init(INIT), .stages(3)) dut_b (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus_b)
    );

    int         n_chk = 0;
    int         n_pass = 0;
    logic [7:0] sb[$];
    logic       exp_ack = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send(input logic [7:0] d, input logic keep);
        @(negedge clk);
        bus_a.SRC_DATA = d;
        bus_a.SRC_TOG  = ~bus_a.SRC_TOG;
        if (keep) sb.push_back(d);
    endtask

    task automatic wait_full(input string tag);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s_valid_e%0d", tag, i), 32'(bus_a.OUT_VALID), 32'(i == 3));
        end
        check({tag, "_data"}, 32'(bus_a.OUT_DATA), 32'(sb.size() > 0 ? sb[0] : 8'hxx));
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        bus_a.OUT_READY = 1'b1;
        @(posedge clk);
        #1;
        exp_ack = ~exp_ack;
        void'(sb.pop_front());
        check({tag, "_ack"}, 32'(bus_a.ACK_TOG), 32'(exp_ack));
        check({tag, "_empty"}, 32'(bus_a.OUT_VALID), 32'd0);
        bus_a.OUT_READY = 1'b0;
    endtask

    initial begin
        bus_a.SRC_DATA = '0; bus_a.SRC_TOG = 1'b0; bus_a.OUT_READY = 1'b0; bus_a.OVERRUN_CLR = 1'b0;
        bus_b.SRC_DATA = '0; bus_b.SRC_TOG = 1'b0; bus_b.OUT_READY = 1'b0; bus_b.OVERRUN_CLR = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus_a.OUT_VALID), 32'd0);
        check("rst_data", 32'(bus_a.OUT_DATA), 32'(INIT));
        check("rst_ack", 32'(bus_a.ACK_TOG), 32'd0);
        check("rst_ovr", 32'(bus_a.OVERRUN), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // depth 3 instance: valid after edge 4
        @(negedge clk);
        bus_b.SRC_DATA = 8'h96;
        bus_b.SRC_TOG  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("depth3_valid_e%0d", i), 32'(bus_b.OUT_VALID), 32'(i == 4));
        end
        check("depth3_data", 32'(bus_b.OUT_DATA), 32'h96);

        // basic transfer with ready already high
        bus_a.OUT_READY = 1'b1;
        send(8'hA5, 1'b1);
        wait_full("basic");
        check("basic_ack_pre", 32'(bus_a.ACK_TOG), 32'(exp_ack));
        @(posedge clk);
        #1;
        exp_ack = ~exp_ack;
        void'(sb.pop_front());
        check("basic_ack", 32'(bus_a.ACK_TOG), 32'(exp_ack));
        check("basic_empty", 32'(bus_a.OUT_VALID), 32'd0);
        bus_a.OUT_READY = 1'b0;

        // back-pressure; source data changes after capture must be ignored
        send(8'h5C, 1'b1);
        wait_full("bp");
        @(negedge clk);
        bus_a.SRC_DATA = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", 32'(bus_a.OUT_VALID), 32'd1);
            check("bp_data", 32'(bus_a.OUT_DATA), 32'(sb[0]));
            check("bp_ack", 32'(bus_a.ACK_TOG), 32'(exp_ack));
        end
        consume("bp");

        // overrun: second word dropped while first is held
        send(8'h11, 1'b1);
        wait_full("ovr_first");
        send(8'h22, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("ovr_flag", 32'(bus_a.OVERRUN), 32'(OVR_EN));
        check("ovr_data", 32'(bus_a.OUT_DATA), 32'h11);
        check("ovr_valid", 32'(bus_a.OUT_VALID), 32'd1);
        check("ovr_ack", 32'(bus_a.ACK_TOG), 32'(exp_ack));
        @(negedge clk);
        bus_a.OVERRUN_CLR = 1'b1;
        @(posedge clk);
        #1;
        check("ovr_clr", 32'(bus_a.OVERRUN), 32'd0);
        bus_a.OVERRUN_CLR = 1'b0;
        consume("ovr");
        repeat (4) @(posedge clk);
        #1;
        check("ovr_no_ghost", 32'(bus_a.OUT_VALID), 32'd0);

        // consume and new edge on the same cycle
        send(8'h33, 1'b1);
        wait_full("sim_first");
        send(8'h44, 1'b1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        bus_a.OUT_READY = 1'b1;
        @(posedge clk);
        #1;
        exp_ack = ~exp_ack;
        void'(sb.pop_front());
        bus_a.OUT_READY = 1'b0;
        check("sim_valid", 32'(bus_a.OUT_VALID), 32'd1);
        check("sim_data", 32'(bus_a.OUT_DATA), 32'(sb[0]));
        check("sim_ack", 32'(bus_a.ACK_TOG), 32'(exp_ack));
        check("sim_ovr", 32'(bus_a.OVERRUN), 32'd0);
        @(posedge clk);
        #1;
        check("sim_hold", 32'(bus_a.OUT_VALID), 32'd1);
        check("sim_ack_hold", 32'(bus_a.ACK_TOG), 32'(exp_ack));
        consume("sim");

        // async reset while FULL (with an overrun pending when enabled)
        send(8'h77, 1'b1);
        wait_full("ar_first");
        send(8'h78, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(bus_a.OUT_VALID), 32'd0);
        check("ar_data", 32'(bus_a.OUT_DATA), 32'(INIT));
        check("ar_ack", 32'(bus_a.ACK_TOG), 32'd0);
        check("ar_ovr", 32'(bus_a.OVERRUN), 32'd0);
        sb.delete();
        exp_ack = 1'b0;
        bus_a.SRC_TOG = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("ar_after", 32'(bus_a.OUT_VALID), 32'd0);

        // transfer works again after reset
        send(8'h3C, 1'b1);
        wait_full("post");
        consume("post");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
